// File: rtl/vga_fb_arbiter.sv
// Single-port, double-buffered frame-buffer scheduler: fixed display fetch slots win,
// the writer fills the remaining cycles into the back bank, and bank swaps wait for vblank.
module vga_fb_arbiter #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int DATA_W = 12,
    parameter int OFS_W  = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pclk,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              DE,
    output logic [DATA_W-1:0] rgb_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [OFS_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_frame_done,
    output logic              swap_pending,
    output logic              disp_bank,
    output logic              mem_en,
    output logic              mem_we,
    output logic [OFS_W:0]    mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state     | meaning
    // RUN       | writer may fill the back bank
    // SWAP_WAIT | frame complete, writer stalled until vblank start flips banks
    typedef enum logic {
        RUN       = 1'b0,
        SWAP_WAIT = 1'b1
    } state_t;

    localparam logic [OFS_W-1:0] FB_WORDS = OFS_W'(FB_W * FB_H);
    localparam logic [OFS_W-1:0] LINE_W   = OFS_W'(FB_W);
    localparam logic [9:0]       VBL_LINE = 10'(2 * FB_H);

    state_t             state;
    state_t             state_next;
    logic               bank_next;
    logic               rd_pend;
    logic               disp_slot;
    logic               vblank_start;
    logic               wr_in_range;
    logic               wr_fire;
    logic [OFS_W-1:0]   rd_offset;

    // One fetch per 2x-upscaled pixel pair, taken on the even column.
    assign disp_slot    = pclk & DE & ~x_pixel[0];
    assign rd_offset    = OFS_W'(y_pixel[9:1]) * LINE_W + OFS_W'(x_pixel[9:1]);
    assign vblank_start = pclk & (y_pixel == VBL_LINE) & (x_pixel == 10'd0);
    assign wr_in_range  = (wr_addr < FB_WORDS);

    assign wr_ready     = (state == RUN) & ~disp_slot & reset;
    assign wr_fire      = wr_valid & wr_ready;
    assign swap_pending = (state == SWAP_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            disp_bank <= 1'b0;
        end else begin
            state     <= state_next;
            disp_bank <= bank_next;
        end
    end

    always_comb begin
        state_next = state;
        bank_next  = disp_bank;
        case (state)
            RUN: begin
                // A frame-done coinciding with vblank start still waits a full frame.
                if (wr_frame_done) state_next = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (vblank_start) begin
                    bank_next  = ~disp_bank;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (disp_slot) begin
                mem_en   = 1'b1;
                mem_addr = {disp_bank, rd_offset};
            end else if (wr_fire && wr_in_range) begin
                // Out-of-range writes complete the handshake but never reach the RAM.
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {~disp_bank, wr_addr};
                mem_wdata = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            rgb_out <= '0;
        end else begin
            rd_pend <= disp_slot;
            if (pclk && !DE) begin
                rgb_out <= '0;
            end else if (rd_pend) begin
                rgb_out <= mem_rdata;
            end
        end
    end

endmodule
